// File: rtl/agc_scaler_if.sv
// agc_scaler_if: FS01/control inputs and divider-chain outputs of agc_scaler.
// SCAFST exists only when AGC_SCALER_FASTADV_EN is defined.
interface agc_scaler_if #(parameter int STAGES = 17);
    logic              FS01;
    logic              SCAINH;
    logic              SCACLR;
`ifdef AGC_SCALER_FASTADV_EN
    logic              SCAFST;
`endif
    logic [STAGES-1:0] FS;
    logic [STAGES-1:0] FA;
    logic [STAGES-1:0] FB;
    logic              SCAWRP;
    logic              FS01_D;
    modport master (
`ifdef AGC_SCALER_FASTADV_EN
        output SCAFST,
`endif
        output FS01, SCAINH, SCACLR,
        input  FS, FA, FB, SCAWRP, FS01_D
    );
    modport slave (
`ifdef AGC_SCALER_FASTADV_EN
        input  SCAFST,
`endif
        input  FS01, SCAINH, SCACLR,
        output FS, FA, FB, SCAWRP, FS01_D
    );
endinterface

// File: rtl/agc_scaler.sv
// agc_scaler: FS01-rise-driven binary divider chain with rise/fall strobes and wrap flag.
// AGC_SCALER_FASTADV_EN adds SCAFST, advancing the chain on every CLOCK edge.
module agc_scaler #(
    parameter int STAGES = 17
) (
    input logic         CLOCK,
    input logic         rst,
    agc_scaler_if.slave bus
);
    logic [STAGES-1:0] cnt_q, cnt_d, fa_q, fb_q;
    logic              fs01_d_q, armed_q, wrp_q;
    logic              rise, adv, fst;
    always_comb begin
`ifdef AGC_SCALER_FASTADV_EN
        fst = bus.SCAFST;
`else
        fst = 1'b0;
`endif
        rise  = bus.FS01 & ~fs01_d_q & armed_q;
        adv   = ~bus.SCAINH & (fst | rise);
        cnt_d = bus.SCACLR ? '0 : adv ? cnt_q + STAGES'(1) : cnt_q;
    end
    // armed_q blocks counting an FS01 that was already high when reset ended
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            cnt_q    <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            wrp_q    <= 1'b0;
            fs01_d_q <= 1'b0;
            armed_q  <= ~bus.FS01;
        end else begin
            cnt_q    <= cnt_d;
            fa_q     <= cnt_d & ~cnt_q;
            fb_q     <= cnt_q & ~cnt_d;
            wrp_q    <= ~bus.SCACLR & adv & (&cnt_q);
            fs01_d_q <= bus.FS01;
            armed_q  <= armed_q | ~bus.FS01;
        end
    end
    assign bus.FS     = cnt_q;
    assign bus.FA     = fa_q;
    assign bus.FB     = fb_q;
    assign bus.SCAWRP = wrp_q;
    assign bus.FS01_D = fs01_d_q;
endmodule

// File: tb/tb_agc_scaler.sv
// tb_agc_scaler: table vectors, directed divide/wrap sequences and random stimulus
// checked every cycle against a counting model; AGC_SCALER_FASTADV_EN adds a fast-advance run.
module tb_agc_scaler;
    localparam int S   = 4;
    localparam int MOD = 1 << S;

    logic CLOCK = 1'b0;
    logic rst   = 1'b1;
    always #5 CLOCK = ~CLOCK;

    agc_scaler_if #(.STAGES(S)) bus ();
    agc_scaler #(.STAGES(S)) dut (.CLOCK(CLOCK), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    int m_cnt, m_fa, m_fb, m_w, m_d, m_arm;

    typedef struct {
        bit r, f, inh, clr;
        int fs, fa, fb, w;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit inh, input bit clr, input bit fst);
        int nxt;
        bit adv;
        @(negedge CLOCK);
        rst = r;
        bus.FS01 = f;
        bus.SCAINH = inh;
        bus.SCACLR = clr;
`ifdef AGC_SCALER_FASTADV_EN
        bus.SCAFST = fst;
`endif
        @(posedge CLOCK);
        if (r) begin
            m_cnt = 0; m_fa = 0; m_fb = 0; m_w = 0; m_d = 0;
            m_arm = !f;
        end else begin
`ifdef AGC_SCALER_FASTADV_EN
            adv = !inh && (fst || (f && !m_d && m_arm));
`else
            adv = !inh && f && !m_d && m_arm;
`endif
            nxt  = clr ? 0 : adv ? (m_cnt + 1) % MOD : m_cnt;
            m_fa = nxt & ~m_cnt;
            m_fb = m_cnt & ~nxt;
            m_w  = (!clr && adv && m_cnt == MOD - 1) ? 1 : 0;
            m_cnt = nxt;
            m_arm = m_arm | !f;
            m_d  = f;
        end
        #1;
        chk("model_FS", int'(bus.FS), m_cnt);
        chk("model_FA", int'(bus.FA), m_fa);
        chk("model_FB", int'(bus.FB), m_fb);
        chk("model_SCAWRP", int'(bus.SCAWRP), m_w);
        chk("model_FS01_D", int'(bus.FS01_D), m_d);
    endtask

    initial begin
        int wraps, fa3, hi;
        bit f;
        bus.FS01 = 1'b0;
        bus.SCAINH = 1'b0;
        bus.SCACLR = 1'b0;
`ifdef AGC_SCALER_FASTADV_EN
        bus.SCAFST = 1'b0;
`endif
        // reset hold with FS01 high, first count, clear collision at 3
        tbl.push_back('{1,1,0,0, 0,0,0,0});
        tbl.push_back('{1,1,0,0, 0,0,0,0});
        tbl.push_back('{1,1,0,0, 0,0,0,0});
        tbl.push_back('{0,1,0,0, 0,0,0,0});
        tbl.push_back('{0,1,0,0, 0,0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0});
        tbl.push_back('{0,1,0,0, 1,1,0,0});
        tbl.push_back('{0,1,0,0, 1,0,0,0});
        tbl.push_back('{0,0,0,0, 1,0,0,0});
        tbl.push_back('{0,1,0,0, 2,2,1,0});
        tbl.push_back('{0,0,0,0, 2,0,0,0});
        tbl.push_back('{0,1,0,0, 3,1,0,0});
        tbl.push_back('{0,0,0,0, 3,0,0,0});
        tbl.push_back('{0,1,0,1, 0,0,3,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0});
        // count to 5, inhibit across 3 rises, release, clear over inhibit
        tbl.push_back('{0,1,0,0, 1,1,0,0});
        tbl.push_back('{0,0,0,0, 1,0,0,0});
        tbl.push_back('{0,1,0,0, 2,2,1,0});
        tbl.push_back('{0,0,0,0, 2,0,0,0});
        tbl.push_back('{0,1,0,0, 3,1,0,0});
        tbl.push_back('{0,0,0,0, 3,0,0,0});
        tbl.push_back('{0,1,0,0, 4,4,3,0});
        tbl.push_back('{0,0,0,0, 4,0,0,0});
        tbl.push_back('{0,1,0,0, 5,1,0,0});
        tbl.push_back('{0,0,1,0, 5,0,0,0});
        tbl.push_back('{0,1,1,0, 5,0,0,0});
        tbl.push_back('{0,0,1,0, 5,0,0,0});
        tbl.push_back('{0,1,1,0, 5,0,0,0});
        tbl.push_back('{0,0,1,0, 5,0,0,0});
        tbl.push_back('{0,1,1,0, 5,0,0,0});
        tbl.push_back('{0,1,0,0, 5,0,0,0});
        tbl.push_back('{0,0,0,0, 5,0,0,0});
        tbl.push_back('{0,1,0,0, 6,2,1,0});
        tbl.push_back('{0,0,1,1, 0,0,6,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0});
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].inh, tbl[i].clr, 1'b0);
            chk("tbl_FS", int'(bus.FS), tbl[i].fs);
            chk("tbl_FA", int'(bus.FA), tbl[i].fa);
            chk("tbl_FB", int'(bus.FB), tbl[i].fb);
            chk("tbl_SCAWRP", int'(bus.SCAWRP), tbl[i].w);
            chk("tbl_FS01_D", int'(bus.FS01_D), tbl[i].r ? 0 : int'(tbl[i].f));
        end

        // divide by FS01 toggling every 4 clocks, through one wrap
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        wraps = 0;
        fa3 = 0;
        for (int k = 1; k <= 16; k++) begin
            for (int c = 0; c < 8; c++) begin
                step(0, c < 4, 0, 0, 0);
                wraps += int'(bus.SCAWRP);
                fa3 += int'(bus.FA[3]);
                if (c == 0 && k == 8) begin
                    chk("div8_FS", int'(bus.FS), 8);
                    chk("div8_FA3", int'(bus.FA[3]), 1);
                    chk("div8_FB", int'(bus.FB), 7);
                end
                if (c == 0 && k == 15) chk("wrap_pre_FS", int'(bus.FS), 15);
                if (c == 0 && k == 16) begin
                    chk("wrap_FS", int'(bus.FS), 0);
                    chk("wrap_SCAWRP", int'(bus.SCAWRP), 1);
                    chk("wrap_FB", int'(bus.FB), 15);
                    chk("wrap_FA", int'(bus.FA), 0);
                end
            end
            if (k == 8) chk("div8_FA3_count", fa3, 1);
        end
        chk("wrap_count", wraps, 1);

        // random traffic against the model
        f = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2) == 0) f = ~f;
            step($urandom_range(63) == 0, f, $urandom_range(7) == 0,
                 $urandom_range(31) == 0, $urandom_range(15) == 0);
        end

`ifdef AGC_SCALER_FASTADV_EN
        step(1, 0, 0, 0, 0);
        wraps = 0;
        hi = 0;
        for (int i = 0; i < MOD; i++) begin
            step(0, 0, 0, 0, 1);
            wraps += int'(bus.SCAWRP);
            hi += int'(bus.FS[S-1]);
        end
        chk("fast_FS", int'(bus.FS), 0);
        chk("fast_wraps", wraps, 1);
        chk("fast_msb_high", hi, MOD / 2);
`else
        hi = 0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
